// File: rtl/ballot_controller_if.sv
// Ballot controller signal bundle.
// master = officer panel / logger side, slave = controller.
interface ballot_controller_if;
   logic       mode;
   logic       enable_ballot;
   logic [3:0] vote_valid;
   logic       vote_strobe;
   logic [1:0] vote_sel;
   logic       ballot_open;
   logic       confirm;
   logic       reject_multi;
   logic       timeout;
   logic [9:0] total_votes;
   logic [1:0] disp_sel;

   modport master (
      output mode,
      output enable_ballot,
      output vote_valid,
      input  vote_strobe,
      input  vote_sel,
      input  ballot_open,
      input  confirm,
      input  reject_multi,
      input  timeout,
      input  total_votes,
      input  disp_sel
   );

   modport slave (
      input  mode,
      input  enable_ballot,
      input  vote_valid,
      output vote_strobe,
      output vote_sel,
      output ballot_open,
      output confirm,
      output reject_multi,
      output timeout,
      output total_votes,
      output disp_sel
   );
endinterface

// File: rtl/ballot_controller.sv
// Voting-machine ballot controller: arms one ballot,
// commits a single vote, holds confirm, scans results.
module ballot_controller #(
   parameter int BALLOT_TIMEOUT = 1000,
   parameter int CONFIRM_CYCLES = 50,
   parameter int SCAN_CYCLES    = 100
) (
   input  logic clock,
   input  logic reset,
   ballot_controller_if.slave bus
);

   localparam int M1 =
      (BALLOT_TIMEOUT > CONFIRM_CYCLES) ?
      BALLOT_TIMEOUT : CONFIRM_CYCLES;
   localparam int MAXP =
      (M1 > SCAN_CYCLES) ? M1 : SCAN_CYCLES;
   localparam int CW = $clog2(MAXP + 1);

   localparam logic [CW-1:0] T_LAST =
      CW'(BALLOT_TIMEOUT - 1);
   localparam logic [CW-1:0] C_LAST =
      CW'(CONFIRM_CYCLES - 1);
   localparam logic [CW-1:0] S_LAST =
      CW'(SCAN_CYCLES - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_COMMIT  = 3'd2;
   localparam logic [2:0] S_HOLD    = 3'd3;
   localparam logic [2:0] S_RESULTS = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          strobe_q, strobe_d;
   logic [1:0]    sel_q, sel_d;
   logic          open_q, open_d;
   logic          confirm_q, confirm_d;
   logic          reject_q, reject_d;
   logic          timeout_q, timeout_d;
   logic [9:0]    total_q, total_d;
   logic [1:0]    disp_q, disp_d;

   logic          single;
   logic          multi;
   logic [1:0]    idx;

   // Classify the vote buttons: exactly one, or several.
   always_comb begin
      single = 1'b0;
      idx    = 2'd0;
      case (bus.vote_valid)
         4'b0001: begin single = 1'b1; idx = 2'd0; end
         4'b0010: begin single = 1'b1; idx = 2'd1; end
         4'b0100: begin single = 1'b1; idx = 2'd2; end
         4'b1000: begin single = 1'b1; idx = 2'd3; end
         default: begin single = 1'b0; idx = 2'd0; end
      endcase
      multi = (bus.vote_valid != 4'b0000) && !single;
   end

   // Next state and next registered outputs; one counter
   // serves as ballot timer, confirm hold and scan timer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      strobe_d  = 1'b0;
      sel_d     = sel_q;
      open_d    = 1'b0;
      confirm_d = 1'b0;
      reject_d  = 1'b0;
      timeout_d = 1'b0;
      total_d   = total_q;
      disp_d    = 2'd0;
      case (state_q)
         S_IDLE: begin
            if (bus.mode) begin
               state_d = S_RESULTS;
               cnt_d   = '0;
            end else if (bus.enable_ballot) begin
               state_d = S_ARMED;
               cnt_d   = '0;
               open_d  = 1'b1;
            end
         end
         S_ARMED: begin
            if (bus.mode) begin
               state_d = S_RESULTS;
               cnt_d   = '0;
            end else if (single) begin
               state_d  = S_COMMIT;
               strobe_d = 1'b1;
               sel_d    = idx;
               if (total_q != 10'h3FF)
                  total_d = total_q + 10'd1;
            end else begin
               reject_d = multi;
               if (cnt_q == T_LAST) begin
                  state_d   = S_IDLE;
                  timeout_d = 1'b1;
               end else begin
                  open_d = 1'b1;
                  cnt_d  = cnt_q + 1'b1;
               end
            end
         end
         S_COMMIT: begin
            cnt_d = '0;
            if (bus.mode) begin
               state_d = S_RESULTS;
            end else begin
               state_d   = S_HOLD;
               confirm_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.mode) begin
               state_d = S_RESULTS;
               cnt_d   = '0;
            end else if (cnt_q == C_LAST) begin
               state_d = S_IDLE;
            end else begin
               confirm_d = 1'b1;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         S_RESULTS: begin
            if (!bus.mode) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == S_LAST) begin
               cnt_d  = '0;
               disp_d = disp_q + 2'd1;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               disp_d = disp_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers, cleared by async reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         strobe_q  <= 1'b0;
         sel_q     <= 2'd0;
         open_q    <= 1'b0;
         confirm_q <= 1'b0;
         reject_q  <= 1'b0;
         timeout_q <= 1'b0;
         total_q   <= 10'd0;
         disp_q    <= 2'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         strobe_q  <= strobe_d;
         sel_q     <= sel_d;
         open_q    <= open_d;
         confirm_q <= confirm_d;
         reject_q  <= reject_d;
         timeout_q <= timeout_d;
         total_q   <= total_d;
         disp_q    <= disp_d;
      end
   end

   assign bus.vote_strobe  = strobe_q;
   assign bus.vote_sel     = sel_q;
   assign bus.ballot_open  = open_q;
   assign bus.confirm      = confirm_q;
   assign bus.reject_multi = reject_q;
   assign bus.timeout      = timeout_q;
   assign bus.total_votes  = total_q;
   assign bus.disp_sel     = disp_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Bench for ballot_controller: directed scenarios
// then random traffic against a phase/age model.
module tb_ballot_controller;
   localparam int BT = 8;
   localparam int CC = 4;
   localparam int SC = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ballot_controller_if bus();

   ballot_controller #(
      .BALLOT_TIMEOUT(BT),
      .CONFIRM_CYCLES(CC),
      .SCAN_CYCLES(SC)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus(bus.slave)
   );

   typedef enum int {
      P_IDLE, P_ARM, P_COM, P_HOLD, P_RES
   } ph_t;

   ph_t ph;
   int  age;
   int  m_sel;
   int  m_total;
   bit  m_to;
   bit  m_rej;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      ph = P_IDLE;
      age = 0;
      m_sel = 0;
      m_total = 0;
      m_to = 0;
      m_rej = 0;
   endtask

   // One clock of ballot rules: phase plus cycles spent in it.
   task automatic model_step(bit m, bit en, logic [3:0] vv);
      ph_t nx;
      int  pop;
      int  ix;
      nx = ph;
      pop = $countones(vv);
      ix = 0;
      for (int i = 0; i < 4; i++) if (vv[i]) ix = i;
      m_to = 0;
      m_rej = 0;
      case (ph)
         P_IDLE: if (m) nx = P_RES; else if (en) nx = P_ARM;
         P_ARM: begin
            if (m) nx = P_RES;
            else if (pop == 1) begin
               nx = P_COM;
               m_sel = ix;
               if (m_total < 1023) m_total++;
            end else begin
               m_rej = (pop >= 2);
               if (age == BT - 1) begin
                  nx = P_IDLE;
                  m_to = 1;
               end
            end
         end
         P_COM: nx = m ? P_RES : P_HOLD;
         P_HOLD: if (m) nx = P_RES;
                 else if (age == CC - 1) nx = P_IDLE;
         P_RES: if (!m) nx = P_IDLE;
         default: nx = P_IDLE;
      endcase
      age = (nx == ph) ? age + 1 : 0;
      ph = nx;
   endtask

   task automatic check_outs();
      int d;
      d = (ph == P_RES) ? (age / SC) % 4 : 0;
      chk("ballot_open", 32'(bus.ballot_open), 32'(ph == P_ARM));
      chk("vote_strobe", 32'(bus.vote_strobe), 32'(ph == P_COM));
      chk("vote_sel", 32'(bus.vote_sel), 32'(m_sel));
      chk("confirm", 32'(bus.confirm), 32'(ph == P_HOLD));
      chk("reject_multi", 32'(bus.reject_multi), 32'(m_rej));
      chk("timeout", 32'(bus.timeout), 32'(m_to));
      chk("total_votes", 32'(bus.total_votes), 32'(m_total));
      chk("disp_sel", 32'(bus.disp_sel), 32'(d));
   endtask

   // Drive inputs at the falling edge, check 1 after rising.
   task automatic cyc(bit m, bit en, logic [3:0] vv);
      bus.mode = m;
      bus.enable_ballot = en;
      bus.vote_valid = vv;
      @(posedge clk);
      model_step(m, en, vv);
      #1;
      check_outs();
      @(negedge clk);
   endtask

   initial begin : main
      bit rm;
      logic [3:0] rv;
      int r;
      bus.mode = 1'b0;
      bus.enable_ballot = 1'b0;
      bus.vote_valid = 4'b0;
      model_reset();
      #12;
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;

      // enable, vote two cycles later, confirm hold
      cyc(0, 1, 4'b0000);
      cyc(0, 0, 4'b0000);
      cyc(0, 0, 4'b0100);
      chk("d_strobe", 32'(bus.vote_strobe), 32'd1);
      chk("d_sel2", 32'(bus.vote_sel), 32'd2);
      chk("d_total1", 32'(bus.total_votes), 32'd1);
      cyc(0, 0, 4'b0000);
      cyc(0, 0, 4'b0010);
      cyc(0, 0, 4'b1001);
      cyc(0, 0, 4'b0000);
      chk("d_conf4", 32'(bus.confirm), 32'd1);
      cyc(0, 0, 4'b0000);
      chk("d_conf_end", 32'(bus.confirm), 32'd0);
      // votes in idle are ignored
      cyc(0, 0, 4'b0001);
      cyc(0, 0, 4'b1100);
      chk("d_idle_tot", 32'(bus.total_votes), 32'd1);

      // multi-button reject, then a valid vote
      cyc(0, 1, 4'b0000);
      cyc(0, 0, 4'b0011);
      chk("d_rej", 32'(bus.reject_multi), 32'd1);
      chk("d_rej_open", 32'(bus.ballot_open), 32'd1);
      cyc(0, 1, 4'b0000);
      cyc(0, 0, 4'b0001);
      chk("d_sel0", 32'(bus.vote_sel), 32'd0);
      repeat (5) cyc(0, 0, 4'b0000);

      // plain timeout
      cyc(0, 1, 4'b0000);
      repeat (8) cyc(0, 0, 4'b0000);
      chk("d_to", 32'(bus.timeout), 32'd1);
      chk("d_to_open", 32'(bus.ballot_open), 32'd0);
      cyc(0, 0, 4'b0000);
      // vote on the expiry cycle wins
      cyc(0, 1, 4'b0000);
      repeat (7) cyc(0, 0, 4'b0000);
      cyc(0, 0, 4'b1000);
      chk("d_exp_sel3", 32'(bus.vote_sel), 32'd3);
      chk("d_exp_noto", 32'(bus.timeout), 32'd0);
      repeat (5) cyc(0, 0, 4'b0000);

      // mode raised while in COMMIT, results scan
      cyc(0, 1, 4'b0000);
      cyc(0, 0, 4'b0010);
      repeat (14) cyc(1, 0, 4'b0110);
      cyc(0, 0, 4'b0000);
      chk("d_res_idle", 32'(bus.disp_sel), 32'd0);

      // async reset while armed
      cyc(0, 1, 4'b0000);
      cyc(0, 0, 4'b0000);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cyc(0, 0, 4'b0000);

      // saturate the vote total
      repeat (1030) begin
         cyc(0, 1, 4'b0000);
         rv = 4'b0001 << $urandom_range(0, 3);
         cyc(0, 0, rv);
         repeat (5) cyc(0, 0, 4'b0000);
      end
      chk("d_sat", 32'(bus.total_votes), 32'd1023);

      // random traffic
      rm = 0;
      repeat (1500) begin
         if ($urandom_range(0, 29) == 0) rm = ~rm;
         r = $urandom_range(0, 9);
         if (r < 6) rv = 4'b0000;
         else if (r < 8) rv = 4'b0001 << $urandom_range(0, 3);
         else rv = 4'($urandom_range(0, 15));
         cyc(rm, ($urandom_range(0, 3) == 0), rv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
